arb_req_queue: RTL and testbench
================================

Name: arb_req_queue

Overview:
- Upstream request stage for the 4-client round-robin arbiter.
- Holds a per-client FIFO of pending transaction words. Drives req[i] high while client i's FIFO is non-empty.
- Consumes the arbiter's one-hot grant to pop the granted FIFO. Presents the popped word, tagged with the client id, on a single output port.

Parameters:
- NUM_CLIENTS, 4, number of clients. Fixed at 4 to match the arbiter's req/grant width.
- DATA_W, 8, width of each transaction word.
- DEPTH, 4, entries per client FIFO. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- push  input  4  push[i] enqueues push_data slice i into FIFO i.
- push_data  input  4*DATA_W  slice i is bits [i*DATA_W +: DATA_W].
- full  output  4  full[i] is high when FIFO i holds DEPTH entries.
- req  output  4  to arbiter; req[i] = (count[i] != 0).
- grant  input  4  from arbiter; one-hot or zero.
- out_valid  output  1  one-cycle strobe; popped word is valid.
- out_data  output  DATA_W  popped word.
- out_id  output  2  index of the client the word came from.
- ovf_err  output  4  sticky; a push to FIFO i was dropped.
- gnt_err  output  1  sticky; an illegal grant was seen.

Behaviour:
- Reset (asynchronous assert, synchronous-edge release) clears:
  - all counts, read pointers and write pointers;
  - out_valid, out_data and out_id to 0;
  - ovf_err and gnt_err to 0.
  - After reset, req=0 and full=0.
- Each FIFO is a circular buffer:
  - read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH;
  - the count is log2(DEPTH)+1 bits.
- req and full are combinational from the counts. There are no other combinational paths from inputs to outputs.
- Push acceptance for client i: accepted when push[i] && (!full[i] || pop[i]).
  - A same-cycle pop frees a slot, so a push to a full FIFO with a simultaneous pop is accepted.
  - A rejected push leaves the FIFO unchanged and sets ovf_err[i]. It stays set until rst.
- Pop for client i: pop[i] = grant[i] && req[i] && grant_legal.
  - grant_legal means grant is zero or exactly one-hot.
- Illegal grants set gnt_err and pop nothing in that cycle. Illegal means either:
  - grant has more than one bit set, or
  - grant[i] is high while req[i] is low.
- Simultaneous push and pop on the same FIFO: the count is unchanged and both pointers advance.
- Pop when count=1 with a simultaneous push: the FIFO stays non-empty and req[i] stays high.
- Output timing:
  - On a pop at edge t, out_valid=1, out_data=head word and out_id=i become visible after edge t and hold for exactly one cycle.
  - In the following cycle out_valid returns to 0 unless another pop occurs.
  - out_data and out_id hold their last value while out_valid=0.
- Latency:
  - push at edge t: req[i] is high after edge t (count updated).
  - The earliest pop is at the edge on which the arbiter presents grant[i].
  - The pop-to-output latency is 1 cycle.
- The arbiter may hold grant[i] for consecutive cycles. One entry is popped per granted cycle while req[i] is high.
- If req[i] drops because the FIFO is emptied while grant[i] is still high, that grant is illegal and sets gnt_err. The arbiter is required to deassert the grant in that cycle.
- Data ordering is strictly FIFO per client. There is no ordering guarantee across clients; ordering across clients is the arbiter's policy.
- rst asserted mid-transfer discards all queued entries and any out_valid in flight immediately.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0, with push=0 and grant=0 -> req=0000, full=0000, out_valid=0, ovf_err=0, gnt_err=0 for 10 cycles.
- Single client ordering: push client 3 with 0xA1, 0xA2, 0xA3 on consecutive cycles; then grant=1000 for 3 cycles -> out_data A1, A2, A3 with out_id=3, each with out_valid=1; req[3] falls after the third pop.
- Full and overflow, DEPTH=4: push 5 words to client 0 with no grant -> full[0]=1 after the 4th push; the 5th push is dropped and ovf_err=0001. Then grant=0001 for 4 cycles -> the first 4 words come out in order.
- Full with simultaneous push/pop: with FIFO 1 full, assert push[1]=1 with 0x55 and grant=0010 in the same cycle -> head popped, 0x55 accepted, count stays 4, ovf_err[1]=0.
- Round-robin integration with the arbiter: load one word per client (0x10, 0x20, 0x30, 0x40 into clients 0..3) with req=1111 -> four out_valid pulses, each out_id distinct, with out_data matching out_id; FIFOs then empty and req=0000.
- Illegal grants: grant=0011, then grant=0100 with req[2]=0 -> gnt_err=1, no out_valid, all counts unchanged.

Source files
------------

// File: rtl/arb_req_queue.sv
// arb_req_queue: per-client request FIFOs feeding a 4-client round-robin arbiter.
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   push, push_data  per-client enqueue strobes and data slices (slice i = [i*DATA_W +: DATA_W])
//   full, req        combinational from counts: FIFO i holds DEPTH entries / is non-empty
//   grant            one-hot or zero grant from the arbiter; pops the granted FIFO
//   out_valid/data/id  registered one-cycle strobe with the popped word and its client index
//   ovf_err, gnt_err sticky error flags: dropped push per client / illegal grant seen
module arb_req_queue #(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLIENTS-1:0]        push,
    input  logic [NUM_CLIENTS*DATA_W-1:0] push_data,
    output logic [NUM_CLIENTS-1:0]        full,
    output logic [NUM_CLIENTS-1:0]        req,
    input  logic [NUM_CLIENTS-1:0]        grant,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic [1:0]                    out_id,
    output logic [NUM_CLIENTS-1:0]        ovf_err,
    output logic                          gnt_err
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0]      mem_q [NUM_CLIENTS][DEPTH];
    logic [AW-1:0]          rp_q  [NUM_CLIENTS];
    logic [AW-1:0]          wp_q  [NUM_CLIENTS];
    logic [AW:0]            cnt_q [NUM_CLIENTS];
    logic [AW:0]            cnt_d [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] pop, acc, ovf_err_q;
    logic                   onehot0, illegal, out_valid_q, gnt_err_q;
    logic [DATA_W-1:0]      pop_data, out_data_q;
    logic [1:0]             pop_id, out_id_q;

    assign onehot0 = (grant & (grant - 1'b1)) == '0;
    // A grant to an empty FIFO is illegal even when one-hot; it pops nothing anyway.
    assign illegal = !onehot0 || |(grant & ~req);
    assign pop     = grant & req & {NUM_CLIENTS{onehot0}};

    always_comb begin
        pop_id   = '0;
        pop_data = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            req[i]   = cnt_q[i] != '0;
            full[i]  = cnt_q[i] == (AW+1)'(DEPTH);
            // A simultaneous pop frees the slot a push to a full FIFO needs.
            acc[i]   = push[i] && (!full[i] || pop[i]);
            cnt_d[i] = cnt_q[i] + (AW+1)'(acc[i]) - (AW+1)'(pop[i]);
            if (pop[i]) begin
                pop_id   = 2'(i);
                pop_data = mem_q[i][rp_q[i]];
            end
        end
    end

    // Storage needs no reset: counts and pointers alone define which entries are live.
    always_ff @(posedge clk)
        for (int i = 0; i < NUM_CLIENTS; i++)
            if (acc[i]) mem_q[i][wp_q[i]] <= push_data[i*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                rp_q[i]  <= '0;
                wp_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            ovf_err_q   <= '0;
            gnt_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                rp_q[i]  <= rp_q[i] + AW'(pop[i]);
                wp_q[i]  <= wp_q[i] + AW'(acc[i]);
                cnt_q[i] <= cnt_d[i];
            end
            ovf_err_q   <= ovf_err_q | (push & ~acc);
            gnt_err_q   <= gnt_err_q | illegal;
            out_valid_q <= |pop;
            if (|pop) begin
                out_data_q <= pop_data;
                out_id_q   <= pop_id;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign ovf_err   = ovf_err_q;
    assign gnt_err   = gnt_err_q;
endmodule

// File: tb/tb_arb_req_queue.sv
// tb_arb_req_queue: directed scoreboard bench for arb_req_queue.
module tb_arb_req_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  push, full, req, grant, ovf_err;
    logic [31:0] push_data;
    logic        out_valid, gnt_err;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic [9:0]  sb [$];
    int          checks = 0;
    int          failures = 0;

    arb_req_queue dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .full(full),
        .req(req), .grant(grant), .out_valid(out_valid), .out_data(out_data),
        .out_id(out_id), .ovf_err(ovf_err), .gnt_err(gnt_err)
    );

    always #5 clk = ~clk;

    // Monitor: every output strobe must match the oldest expected {id,data}.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            logic [9:0] e;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected act id=%0d data=%h exp none", out_id, out_data);
            end else begin
                e = sb.pop_front();
                if ({out_id, out_data} !== e) begin
                    failures++;
                    $display("FAIL out_word act id=%0d data=%h exp id=%0d data=%h",
                             out_id, out_data, e[9:8], e[7:0]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", n, a, e);
        end
    endtask

    task automatic push1(input int c, input logic [7:0] d);
        push = 4'(1 << c);
        push_data = '0;
        push_data[c*8 +: 8] = d;
        tick;
        push = '0;
    endtask

    task automatic gnt1(input int c, input logic [7:0] d);
        grant = 4'(1 << c);
        sb.push_back({2'(c), d});
        tick;
        grant = '0;
    endtask

    initial begin
        rst = 1'b1; push = '0; push_data = '0; grant = '0;
        tick; tick;
        rst = 1'b0;
        // reset then idle
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle", {req, full, out_valid, ovf_err, gnt_err}, 32'h0);
        end
        check("rst_out", {out_id, out_data}, 32'h0);
        #1;
        // single client ordering
        push1(3, 8'hA1); push1(3, 8'hA2); push1(3, 8'hA3);
        check("c3_req", req, 32'h8);
        gnt1(3, 8'hA1); gnt1(3, 8'hA2); gnt1(3, 8'hA3);
        check("c3_req_drop", req, 32'h0);
        // full and overflow on client 0
        push1(0, 8'hB0); push1(0, 8'hB1); push1(0, 8'hB2);
        check("c0_not_full", full, 32'h0);
        push1(0, 8'hB3);
        check("c0_full", full, 32'h1);
        check("c0_no_ovf", ovf_err, 32'h0);
        push1(0, 8'hB4);
        check("c0_ovf", ovf_err, 32'h1);
        check("c0_still_full", full, 32'h1);
        gnt1(0, 8'hB0); gnt1(0, 8'hB1); gnt1(0, 8'hB2); gnt1(0, 8'hB3);
        check("c0_empty", req, 32'h0);
        // full with simultaneous push and pop on client 1
        push1(1, 8'hC0); push1(1, 8'hC1); push1(1, 8'hC2); push1(1, 8'hC3);
        check("c1_full", full, 32'h2);
        push = 4'b0010; push_data = 32'h0000_5500; grant = 4'b0010;
        sb.push_back({2'd1, 8'hC0});
        tick;
        push = '0; grant = '0;
        check("c1_full_kept", full, 32'h2);
        check("c1_no_ovf", ovf_err, 32'h1);
        gnt1(1, 8'hC1); gnt1(1, 8'hC2); gnt1(1, 8'hC3); gnt1(1, 8'h55);
        check("c1_empty", req, 32'h0);
        // one word per client, round-robin grants
        push = 4'b1111; push_data = {8'h40, 8'h30, 8'h20, 8'h10};
        tick;
        push = '0;
        check("rr_req", req, 32'hF);
        gnt1(0, 8'h10); gnt1(1, 8'h20); gnt1(2, 8'h30); gnt1(3, 8'h40);
        check("rr_empty", req, 32'h0);
        tick;
        check("hold_out", {out_valid, out_id, out_data}, {21'h0, 1'b0, 2'd3, 8'h40});
        check("no_gnt_err", gnt_err, 32'h0);
        // illegal grant: two bits set
        push = 4'b0011; push_data = {16'h0, 8'hD1, 8'hD0};
        tick;
        push = '0;
        grant = 4'b0011;
        tick;
        grant = '0;
        check("multi_gnt_err", gnt_err, 32'h1);
        check("multi_gnt_cnt", req, 32'h3);
        // reset mid-transfer discards everything
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst_clear", {req, full, ovf_err, gnt_err, out_valid, out_id, out_data}, 32'h0);
        // illegal grant: grant to an empty client
        push1(1, 8'hE1);
        grant = 4'b0100;
        tick;
        grant = '0;
        check("empty_gnt_err", gnt_err, 32'h1);
        check("empty_gnt_cnt", req, 32'h2);
        gnt1(1, 8'hE1);
        check("final_empty", req, 32'h0);
        tick; tick;
        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
